hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline; it is the companion to the forwarding unit.
- It covers the hazards forwarding cannot resolve: load-use dependencies, data-memory wait cycles and taken-branch fetch squash.
- It drives the PC/IF_ID write enables, the ID_EX bubble insert and the IF flush, and keeps a stall-cycle performance counter and a memory-timeout flag.

Parameters:
- LOAD_USE_STALLS, 1: bubbles inserted per load-use hazard. Legal range 1..3.
- MEM_TIMEOUT, 255: maximum consecutive DMem_Stall cycles before Mem_Timeout is set. Legal range 1..65535.
- CNT_W, 16: width of Stall_Count.

Ports:
- clk_i  in  1  pipeline clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- IF_ID_RegRs  in  5  rs field of the instruction in ID
- IF_ID_RegRt  in  5  rt field of the instruction in ID
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegRt  in  5  destination of the load in EX
- Branch_Taken  in  1  branch resolved taken in ID this cycle
- DMem_Stall  in  1  data memory busy; the whole pipeline must freeze
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF_ID register update enable
- ID_EX_Bubble  out  1  force ID_EX control fields to zero (NOP)
- IF_Flush  out  1  squash the instruction being fetched into IF_ID
- Stall_All  out  1  freeze EX_MEM and MEM_WB registers
- Stall_Count  out  CNT_W  saturating count of cycles with PC_Write=0
- Mem_Timeout  out  1  sticky memory-timeout error flag

Behaviour:
- State register values: RUN, LOAD_USE, MEM_WAIT.
- Bubble counter bcnt: 2 bits. Wait counter wcnt: 16 bits.
- Outputs are combinational from state, counters and current inputs. All sequential updates happen on the rising edge of clk_i.

Reset (rst_i=1, sampled at clk_i edge):
- state=RUN, bcnt=0, wcnt=0, Stall_Count=0, Mem_Timeout=0.
- While rst_i is high, outputs are forced: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_Flush=0, Stall_All=0.
- Reset mid-stall aborts the stall immediately; there is no residual bubble afterwards.

Hazard terms:
- lu = ID_EX_MemRead && ID_EX_RegRt!=0 && (ID_EX_RegRt==IF_ID_RegRs || ID_EX_RegRt==IF_ID_RegRt).

Priority, highest first: DMem_Stall, then load-use, then branch flush.

RUN state:
- DMem_Stall=1:
  - Freeze: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_Flush=0, Stall_All=1.
  - Next state MEM_WAIT, wcnt=1.
- Else lu=1:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_Flush=0. Branch_Taken is ignored this cycle.
  - If LOAD_USE_STALLS>1: next state LOAD_USE, bcnt=LOAD_USE_STALLS-1. Otherwise stay in RUN.
- Else Branch_Taken=1: IF_Flush=1, all enables 1, ID_EX_Bubble=0.
- Else: PC_Write=1, IF_ID_Write=1, all other outputs 0.

LOAD_USE state:
- Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. lu is not re-evaluated.
- bcnt decrements each cycle; at bcnt==1 the next state is RUN.
- DMem_Stall=1 preempts: apply the freeze outputs, hold bcnt, next state MEM_WAIT.
- When DMem_Stall releases, resume LOAD_USE with bcnt held (not RUN).

MEM_WAIT state:
- Freeze outputs are held while DMem_Stall=1.
- wcnt increments each cycle and saturates at 0xFFFF.
- When wcnt reaches MEM_TIMEOUT, Mem_Timeout is set. It stays set until rst_i.
- DMem_Stall=0: wcnt=0. Next state is LOAD_USE if bcnt!=0, else RUN. In that same cycle, the RUN/LOAD_USE output rules apply to the current inputs.

Stall_Count:
- Increments on every non-reset cycle with PC_Write=0.
- Saturates at all-ones; it does not wrap.

Branch re-evaluation:
- A branch suppressed by a stall is re-evaluated from the held IF_ID on the cycle after the stall ends.

Test Plan:
- lw $2 in EX (ID_EX_MemRead=1, ID_EX_RegRt=2) with ID rs=2, default params -> exactly 1 cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; Stall_Count=1; next cycle all enables 1.
- Same hazard with ID_EX_RegRt=0, and separately with ID_EX_MemRead=0 and a matching register -> no stall; Stall_Count stays 0.
- LOAD_USE_STALLS=2, lu with Branch_Taken=1 -> 2 bubble cycles with IF_Flush=0 throughout; Branch_Taken held on the next cycle -> IF_Flush=1 for 1 cycle.
- DMem_Stall high for 3 cycles, arriving mid LOAD_USE with LOAD_USE_STALLS=3 -> Stall_All=1 and ID_EX_Bubble=0 for 3 cycles, then the remaining bubbles complete; Stall_Count = 3 + 3 = 6.
- MEM_TIMEOUT=4, DMem_Stall held 6 cycles -> Mem_Timeout rises on cycle 4 and stays 1 after the release.
- Assert rst_i for 1 cycle in the middle of MEM_WAIT -> all counters 0, Mem_Timeout=0, state RUN; normal enables (PC_Write=1) on the first cycle after rst_i falls.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush controller for the 5-stage MIPS pipeline.
// Resolves the hazards forwarding cannot: load-use dependencies (bubble
// insertion), data-memory wait cycles (full freeze) and taken-branch fetch
// squash. Also keeps a saturating stall-cycle counter and a sticky
// memory-timeout flag.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), synchronous active-high reset
//   IF_ID_RegRs/IF_ID_RegRt       source registers of the instruction in ID
//   ID_EX_MemRead/ID_EX_RegRt     load in EX and its destination register
//   Branch_Taken                  branch resolved taken in ID
//   DMem_Stall                    data memory busy, freeze the whole pipeline
//   PC_Write/IF_ID_Write          front-end update enables
//   ID_EX_Bubble                  zero the ID_EX control fields
//   IF_Flush                      squash the instruction being fetched
//   Stall_All                     freeze EX_MEM and MEM_WB
//   Stall_Count                   saturating count of cycles with PC_Write=0
//   Mem_Timeout                   sticky memory-timeout error flag
module hazard_control_unit #(
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RegRs,
    input  logic [4:0]       IF_ID_RegRt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegRt,
    input  logic             Branch_Taken,
    input  logic             DMem_Stall,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_Flush,
    output logic             Stall_All,
    output logic [CNT_W-1:0] Stall_Count,
    output logic             Mem_Timeout
);

    localparam int unsigned WCNT_W = 16;
    localparam logic [1:0]        LU_INIT  = 2'(LOAD_USE_STALLS - 1);
    localparam logic [WCNT_W-1:0] TIMEOUT  = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic                mem_timeout_q, mem_timeout_d;
    logic                lu_c;

    // Load-use hazard: load in EX writes a register the ID instruction reads.
    assign lu_c = ID_EX_MemRead && (ID_EX_RegRt != 5'd0) &&
                  ((ID_EX_RegRt == IF_ID_RegRs) || (ID_EX_RegRt == IF_ID_RegRt));

    // Next state, counters and combinational pipeline controls.
    always_comb begin
        state_e eff_c;

        state_d      = state_q;
        bcnt_d       = bcnt_q;
        wcnt_d       = wcnt_q;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_Flush     = 1'b0;
        Stall_All    = 1'b0;
        eff_c        = state_q;

        // On the memory release cycle the state we return to already governs
        // this cycle's outputs, so the pending bubbles are not lengthened.
        if (state_q == MEM_WAIT && !DMem_Stall) begin
            wcnt_d = '0;
            eff_c  = (bcnt_q != 2'd0) ? LOAD_USE : RUN;
        end

        case (eff_c)
            RUN: begin
                state_d = RUN;
                if (DMem_Stall) begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Stall_All   = 1'b1;
                    state_d     = MEM_WAIT;
                    wcnt_d      = WCNT_W'(1);
                end else if (lu_c) begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    if (LOAD_USE_STALLS > 32'd1) begin
                        state_d = LOAD_USE;
                        bcnt_d  = LU_INIT;
                    end
                end else if (Branch_Taken) begin
                    IF_Flush = 1'b1;
                end
            end
            LOAD_USE: begin
                if (DMem_Stall) begin
                    // Freeze preempts the bubble sequence; bcnt is held.
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Stall_All   = 1'b1;
                    state_d     = MEM_WAIT;
                    wcnt_d      = WCNT_W'(1);
                end else begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    bcnt_d       = bcnt_q - 2'd1;
                    state_d      = (bcnt_q == 2'd1) ? RUN : LOAD_USE;
                end
            end
            MEM_WAIT: begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                Stall_All   = 1'b1;
                state_d     = MEM_WAIT;
                if (wcnt_q != WCNT_MAX) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                bcnt_d  = '0;
                wcnt_d  = '0;
            end
        endcase

        if (rst_i) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            IF_Flush     = 1'b0;
            Stall_All    = 1'b0;
        end

        stall_count_d = stall_count_q;
        if (!PC_Write && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end

        mem_timeout_d = mem_timeout_q |
                        ((state_d == MEM_WAIT) && (wcnt_d >= TIMEOUT));
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RUN;
            bcnt_q        <= '0;
            wcnt_q        <= '0;
            stall_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            wcnt_q        <= wcnt_d;
            stall_count_q <= stall_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign Stall_Count = stall_count_q;
    assign Mem_Timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit: three instances with different
// parameters share one stimulus; a vector table exercises the default
// instance and hand-written sequences cover the multi-cycle corner cases.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs, rt, exrt;
    logic       mr, br, dm;

    logic        pcw1, ifw1, bub1, fl1, sa1, to1;
    logic [15:0] cnt1;
    logic        pcw2, ifw2, bub2, fl2, sa2, to2;
    logic [1:0]  cnt2;
    logic        pcw3, ifw3, bub3, fl3, sa3, to3;
    logic [15:0] cnt3;
    logic [4:0]  ctl1, ctl2, ctl3;

    assign ctl1 = {pcw1, ifw1, bub1, fl1, sa1};
    assign ctl2 = {pcw2, ifw2, bub2, fl2, sa2};
    assign ctl3 = {pcw3, ifw3, bub3, fl3, sa3};

    // Control patterns: {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_Flush, Stall_All}
    localparam logic [4:0] RUNC = 5'b11000;
    localparam logic [4:0] STL  = 5'b00100;
    localparam logic [4:0] FLS  = 5'b11010;
    localparam logic [4:0] FRZ  = 5'b00001;
    localparam logic [4:0] RSTC = 5'b00100;

    hazard_control_unit u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RegRs(rs), .IF_ID_RegRt(rt),
        .ID_EX_MemRead(mr), .ID_EX_RegRt(exrt),
        .Branch_Taken(br), .DMem_Stall(dm),
        .PC_Write(pcw1), .IF_ID_Write(ifw1), .ID_EX_Bubble(bub1),
        .IF_Flush(fl1), .Stall_All(sa1),
        .Stall_Count(cnt1), .Mem_Timeout(to1)
    );

    hazard_control_unit #(.LOAD_USE_STALLS(2), .MEM_TIMEOUT(255), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RegRs(rs), .IF_ID_RegRt(rt),
        .ID_EX_MemRead(mr), .ID_EX_RegRt(exrt),
        .Branch_Taken(br), .DMem_Stall(dm),
        .PC_Write(pcw2), .IF_ID_Write(ifw2), .ID_EX_Bubble(bub2),
        .IF_Flush(fl2), .Stall_All(sa2),
        .Stall_Count(cnt2), .Mem_Timeout(to2)
    );

    hazard_control_unit #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(4), .CNT_W(16)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RegRs(rs), .IF_ID_RegRt(rt),
        .ID_EX_MemRead(mr), .ID_EX_RegRt(exrt),
        .Branch_Taken(br), .DMem_Stall(dm),
        .PC_Write(pcw3), .IF_ID_Write(ifw3), .ID_EX_Bubble(bub3),
        .IF_Flush(fl3), .Stall_All(sa3),
        .Stall_Count(cnt3), .Mem_Timeout(to3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] exrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       dm;
        logic [4:0] ctl;
        int         cnt;
        logic       to;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic m, input logic [4:0] e,
                          input logic [4:0] s, input logic [4:0] t,
                          input logic b, input logic d);
        rst = r; mr = m; exrt = e; rs = s; rt = t; br = b; dm = d;
    endtask

    // Advance one rising edge; inputs change and outputs are sampled mid-low-phase.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // Default instance vectors; cnt/to are the values held before the cycle's edge.
        vt[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RSTC, 0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUNC, 0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 5'd2, 5'd2, 5'd9, 1'b0, 1'b0, STL,  0, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 5'd0, 5'd2, 5'd9, 1'b0, 1'b0, RUNC, 1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUNC, 1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, RUNC, 1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, STL,  1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, FLS,  2, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, STL,  2, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, FLS,  3, 1'b0};
        vt[10] = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, FRZ,  3, 1'b0};
        vt[11] = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, FRZ,  4, 1'b0};
        vt[12] = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, STL,  5, 1'b0};
        vt[13] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, FLS,  6, 1'b0};
        vt[14] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUNC, 6, 1'b0};
        vt[15] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RSTC, 6, 1'b0};
        vt[16] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUNC, 0, 1'b0};

        set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();

        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].rst, vt[i].mr, vt[i].exrt, vt[i].rs, vt[i].rt, vt[i].br, vt[i].dm);
            #1;
            chk($sformatf("v%0d_ctl", i), 32'(ctl1), 32'(vt[i].ctl));
            chk($sformatf("v%0d_cnt", i), 32'(cnt1), 32'(vt[i].cnt));
            chk($sformatf("v%0d_to", i),  32'(to1),  32'(vt[i].to));
            step();
        end

        // A: two-bubble load-use with a suppressed branch, then the branch flushes.
        set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0); #1;
        chk("A_bub1", 32'(ctl2), 32'(STL)); step();
        #1; chk("A_bub2", 32'(ctl2), 32'(STL)); step();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); #1;
        chk("A_flush", 32'(ctl2), 32'(FLS)); step();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
        chk("A_run", 32'(ctl2), 32'(RUNC));
        chk("A_cnt", 32'(cnt2), 32'd2);
        step();

        // B: memory stall arrives mid three-bubble load-use.
        set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
        set_in(1'b0, 1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b0); #1;
        chk("B_bub_first", 32'(ctl3), 32'(STL)); step();
        for (int k = 0; k < 3; k++) begin
            dm = 1'b1; #1;
            chk($sformatf("B_frz%0d", k), 32'(ctl3), 32'(FRZ)); step();
        end
        dm = 1'b0; #1;
        chk("B_bub_resume1", 32'(ctl3), 32'(STL)); step();
        #1; chk("B_bub_resume2", 32'(ctl3), 32'(STL)); step();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
        chk("B_run", 32'(ctl3), 32'(RUNC));
        chk("B_cnt", 32'(cnt3), 32'd6);
        chk("B_to", 32'(to3), 32'd0);
        step();

        // C: six-cycle memory stall against MEM_TIMEOUT=4.
        set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
        for (int k = 1; k <= 6; k++) begin
            set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #1;
            chk($sformatf("C_frz%0d", k), 32'(ctl3), 32'(FRZ));
            chk($sformatf("C_to%0d", k), 32'(to3), (k >= 5) ? 32'd1 : 32'd0);
            step();
        end
        dm = 1'b0; #1;
        chk("C_release", 32'(ctl3), 32'(RUNC));
        chk("C_to_held", 32'(to3), 32'd1);
        chk("C_cnt_sat", 32'(cnt2), 32'd3);
        chk("C_to_dflt", 32'(to1), 32'd0);
        step();
        #1; chk("C_to_sticky", 32'(to3), 32'd1);
        step();

        // D: reset in the middle of a memory wait.
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); step();
        step();
        rst = 1'b1; #1;
        chk("D_rst_ctl", 32'(ctl1), 32'(RSTC)); step();
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
        chk("D_run1", 32'(ctl1), 32'(RUNC));
        chk("D_cnt1", 32'(cnt1), 32'd0);
        chk("D_run3", 32'(ctl3), 32'(RUNC));
        chk("D_to3", 32'(to3), 32'd0);
        chk("D_cnt3", 32'(cnt3), 32'd0);
        step();
        #1; chk("D_run_next", 32'(ctl1), 32'(RUNC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
